// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sign-magnitude multiplier datapath: converter FSM states and the
// product-width helper also used by the output converter.
package multiplicador_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      LOAD    = 2'd2,
      WAIT    = 2'd3
   } state_t;

   localparam int unsigned WordLengthDefault = 8;

   function automatic int unsigned product_width(input int unsigned word_length);
      return 2 * word_length;
   endfunction

   localparam int unsigned ProductWidthDefault = product_width(WordLengthDefault);

endpackage

// File: rtl/magnitud_comb.sv
// Combinational two's-complement to magnitude split. The most-negative value maps to
// 2^(Word_Length-1) as an unsigned number, so no overflow flag is needed.
module magnitud_comb #(
   parameter int unsigned Word_Length = 8
) (
   input  logic [Word_Length-1:0] operand_i,
   output logic [Word_Length-1:0] magnitude_o,
   output logic                   msb_o
);

   logic [Word_Length-1:0] negated;

   always_comb begin
      msb_o       = operand_i[Word_Length-1];
      negated     = '0 - operand_i;
      magnitude_o = msb_o ? negated : operand_i;
   end

endmodule

// File: rtl/conversor_entrada_signo_magnitud.sv
// Input converter: captures a signed operand pair, splits it into magnitudes plus a product
// sign, pulses Load to the multiplier core and holds everything until the core reports Done.
module conversor_entrada_signo_magnitud
   import multiplicador_pkg::*;
#(
   parameter int unsigned Word_Length = WordLengthDefault
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   Start_Input,
   input  logic [Word_Length-1:0] Multiplicand_Input,
   input  logic [Word_Length-1:0] Multiplier_Input,
   input  logic                   Done_Input,
   output logic [Word_Length-1:0] Multiplicand_Mag_Output,
   output logic [Word_Length-1:0] Multiplier_Mag_Output,
   output logic                   Sign_Output,
   output logic                   Zero_Output,
   output logic                   Load_Output,
   output logic                   Busy_Output
);

   state_t state_q, state_d;

   logic [Word_Length-1:0] mcand_raw_q, mplier_raw_q;
   logic [Word_Length-1:0] mcand_mag_q, mplier_mag_q;
   logic [Word_Length-1:0] mcand_mag_d, mplier_mag_d;
   logic                   sign_q, sign_d;
   logic                   zero_q, zero_d;
   logic                   mcand_msb, mplier_msb;
   logic                   capture_en, convert_en;

   magnitud_comb #(
      .Word_Length (Word_Length)
   ) u_mag_mcand (
      .operand_i   (mcand_raw_q),
      .magnitude_o (mcand_mag_d),
      .msb_o       (mcand_msb)
   );

   magnitud_comb #(
      .Word_Length (Word_Length)
   ) u_mag_mplier (
      .operand_i   (mplier_raw_q),
      .magnitude_o (mplier_mag_d),
      .msb_o       (mplier_msb)
   );

   // Start has priority over Done in IDLE simply because Done is not looked at there.
   always_comb begin
      state_d    = state_q;
      capture_en = 1'b0;
      convert_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Start_Input) begin
               capture_en = 1'b1;
               state_d    = CONVERT;
            end
         end
         CONVERT: begin
            convert_en = 1'b1;
            state_d    = LOAD;
         end
         LOAD: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (Done_Input) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A zero operand forces a positive sign so the product is always +0.
   always_comb begin
      zero_d = (mcand_raw_q == '0) || (mplier_raw_q == '0);
      sign_d = (mcand_msb ^ mplier_msb) & ~zero_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_raw_q  <= '0;
         mplier_raw_q <= '0;
      end else if (capture_en) begin
         mcand_raw_q  <= Multiplicand_Input;
         mplier_raw_q <= Multiplier_Input;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_mag_q  <= '0;
         mplier_mag_q <= '0;
         sign_q       <= 1'b0;
         zero_q       <= 1'b0;
      end else if (convert_en) begin
         mcand_mag_q  <= mcand_mag_d;
         mplier_mag_q <= mplier_mag_d;
         sign_q       <= sign_d;
         zero_q       <= zero_d;
      end
   end

   always_comb begin
      Multiplicand_Mag_Output = mcand_mag_q;
      Multiplier_Mag_Output   = mplier_mag_q;
      Sign_Output             = sign_q;
      Zero_Output             = zero_q;
      Load_Output             = (state_q == LOAD);
      Busy_Output             = (state_q != IDLE);
   end

   a_load_one_cycle : assert property (@(posedge clk) disable iff (rst)
      Load_Output |=> !Load_Output);

   a_load_to_wait : assert property (@(posedge clk) disable iff (rst)
      (state_q == LOAD) |=> (state_q == WAIT));

   a_hold_in_wait : assert property (@(posedge clk) disable iff (rst)
      (state_q == WAIT) |=> ($stable(mcand_mag_q) && $stable(mplier_mag_q) &&
                             $stable(sign_q) && $stable(zero_q)));

endmodule
